// File: rtl/sram_arbiter.sv
// Two-port (fetch/data) arbiter for an asynchronous 32-bit SRAM.
// Data has priority; a fetch wins after MAX_D back-to-back data grants.
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int WAIT   = 2,
  parameter int MAX_D  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_sel,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              stall_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic [31:0]       sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    WREC
  } state_t;

  localparam int DW = $clog2(MAX_D + 1);
  localparam logic [2:0]    CNT_INIT = 3'(WAIT - 1);
  localparam logic [DW-1:0] DMAX     = DW'(MAX_D);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            own_q, own_d;

  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wdoe_q, wdoe_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic       if_elig, d_elig, f_win;
  logic       gnt_d, gnt_f;
  logic [3:0] wbe_n;
  logic [31:0] wdat;

  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         d_addr[31:ADDR_W+2]};

  // An acked requester sits out its ack cycle so it can drop its request.
  assign if_elig = if_req & ~if_ack_q;
  assign d_elig  = d_req & ~d_ack_q;
  assign f_win   = if_elig & (dcnt_q == DMAX);
  assign gnt_d   = (state_q == IDLE) & d_elig & ~f_win;
  assign gnt_f   = (state_q == IDLE) & if_elig & ~gnt_d;

  assign stall_req = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

  // Store lane enables and lane-replicated store data.
  always_comb begin
    wbe_n = 4'b0000;
    wdat  = d_wdata;
    unique case (d_sel)
      2'b01: begin
        wbe_n = ~(4'b0001 << d_addr[1:0]);
        wdat  = {4{d_wdata[7:0]}};
      end
      2'b10: begin
        wbe_n = d_addr[1] ? 4'b0011 : 4'b1100;
        wdat  = {2{d_wdata[15:0]}};
      end
      default: begin
        wbe_n = 4'b0000;
        wdat  = d_wdata;
      end
    endcase
  end

  // State, access counter, data-streak counter and owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      own_q   <= own_d;
    end
  end

  // Next-state logic: grant in IDLE, count down the access window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    own_d   = own_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          own_d   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = d_we ? WR : RD;
          dcnt_d  = (dcnt_q == DMAX) ? dcnt_q : dcnt_q + 1'b1;
        end else if (gnt_f) begin
          own_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = RD;
          dcnt_d  = '0;
        end
      end
      RD: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      WR: begin
        if (cnt_q == 3'd0) state_d = WREC;
        else               cnt_d   = cnt_q - 3'd1;
      end
      WREC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered SRAM strobes, acks and read data.
  always_comb begin
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    be_n_d     = 4'hF;
    wdoe_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d || gnt_f) begin
          ce_n_d = 1'b0;
          addr_d = gnt_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          if (gnt_d && d_we) begin
            we_n_d  = 1'b0;
            wdoe_d  = 1'b1;
            be_n_d  = wbe_n;
            wdata_d = wdat;
          end else begin
            oe_n_d = 1'b0;
            be_n_d = 4'b0000;
          end
        end
      end
      RD: begin
        if (cnt_q != 3'd0) begin
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = be_n_q;
        end else if (own_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = sram_rdata;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = sram_rdata;
        end
      end
      WR: begin
        wdoe_d = 1'b1;
        if (cnt_q != 3'd0) begin
          ce_n_d = 1'b0;
          we_n_d = 1'b0;
          be_n_d = be_n_q;
        end else if (own_q) begin
          d_ack_d = 1'b1;
        end else begin
          if_ack_d = 1'b1;
        end
      end
      WREC: wdoe_d = 1'b0;
      default: wdoe_d = 1'b0;
    endcase
  end

  // Output registers; everything the SRAM sees comes straight off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= 4'hF;
      wdoe_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      wdoe_q     <= wdoe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_be_n     = be_n_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_wdata_oe = wdoe_q;
  assign if_ack        = if_ack_q;
  assign d_ack         = d_ack_q;
  assign if_rdata      = if_rdata_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (WAIT=2, MAX_D=4).
// SRAM read data is a fixed function of the word address.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_sel = 2'b00;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_req;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;
  logic [31:0] sram_wdata;
  logic        sram_wdata_oe;
  logic [31:0] sram_rdata;

  int total = 0;
  int passed = 0;
  int dacks;
  int ifc;

  always #5 clk = ~clk;

  assign sram_rdata = {12'hA5A, sram_addr};

  sram_arbiter #(.ADDR_W(20), .WAIT(2), .MAX_D(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_req(stall_req),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_wdata(sram_wdata),
    .sram_wdata_oe(sram_wdata_oe), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_wdoe", 32'(sram_wdata_oe), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_wdata", sram_wdata, 32'h0);
    chk("rst_acks", {30'b0, if_ack, d_ack}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // single fetch
    if_req = 1'b1;
    if_addr = 32'h8000_0010;
    #1 chk("f_stall", 32'(stall_req), 32'h1);
    tick();
    chk("f_c1_addr", 32'(sram_addr), 32'h4);
    chk("f_c1_ce", {30'b0, sram_ce_n, sram_oe_n}, 32'h0);
    chk("f_c1_be", 32'(sram_be_n), 32'h0);
    chk("f_c1_ack", 32'(if_ack), 32'h0);
    tick();
    chk("f_c2_ce", {30'b0, sram_ce_n, sram_oe_n}, 32'h0);
    tick();
    chk("f_c3_ack", 32'(if_ack), 32'h1);
    chk("f_c3_ce", {30'b0, sram_ce_n, sram_oe_n}, 32'h3);
    chk("f_c3_rdata", if_rdata, 32'hA5A0_0004);
    chk("f_c3_stall", 32'(stall_req), 32'h0);
    if_req = 1'b0;
    tick();
    chk("f_c4_ack", 32'(if_ack), 32'h0);
    chk("f_c4_hold", if_rdata, 32'hA5A0_0004);

    // simultaneous load and fetch
    if_req = 1'b1;
    if_addr = 32'h100;
    d_req = 1'b1;
    d_we = 1'b0;
    d_sel = 2'b01;
    d_addr = 32'h200;
    tick();
    chk("df_c1_addr", 32'(sram_addr), 32'h80);
    chk("df_c1_oe", 32'(sram_oe_n), 32'h0);
    chk("df_c1_be", 32'(sram_be_n), 32'h0);
    tick();
    tick();
    chk("df_c3_dack", 32'(d_ack), 32'h1);
    chk("df_c3_iack", 32'(if_ack), 32'h0);
    chk("df_c3_drd", d_rdata, 32'hA5A0_0080);
    d_req = 1'b0;
    tick();
    chk("df_c4_addr", 32'(sram_addr), 32'h40);
    chk("df_c4_ce", 32'(sram_ce_n), 32'h0);
    chk("df_c4_dack", 32'(d_ack), 32'h0);
    tick();
    tick();
    chk("df_c6_iack", 32'(if_ack), 32'h1);
    chk("df_c6_ird", if_rdata, 32'hA5A0_0040);
    if_req = 1'b0;
    tick();

    // data streak limit with stores and a pending fetch
    d_req = 1'b1;
    d_we = 1'b1;
    d_sel = 2'b00;
    d_addr = 32'h10;
    d_wdata = 32'h1234_5678;
    if_req = 1'b1;
    if_addr = 32'h600;
    dacks = 0;
    ifc = 0;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (d_ack) dacks++;
      if (if_ack && ifc == 0) ifc = c;
      if (c == 1) begin
        chk("s_c1_we", {30'b0, sram_ce_n, sram_we_n}, 32'h0);
        chk("s_c1_wdoe", 32'(sram_wdata_oe), 32'h1);
        chk("s_c1_be", 32'(sram_be_n), 32'h0);
        chk("s_c1_wd", sram_wdata, 32'h1234_5678);
        chk("s_c1_addr", 32'(sram_addr), 32'h4);
      end
      if (c == 3) begin
        chk("s_wrec_ce", {30'b0, sram_ce_n, sram_we_n}, 32'h3);
        chk("s_wrec_wdoe", 32'(sram_wdata_oe), 32'h1);
        chk("s_wrec_ack", 32'(d_ack), 32'h1);
        chk("s_wrec_addr", 32'(sram_addr), 32'h4);
      end
      if (c == 4) chk("s_c4_wdoe", 32'(sram_wdata_oe), 32'h0);
      if (c == 16) chk("s_dcnt_max", 32'(dut.dcnt_q), 32'h4);
      if (c == 17) begin
        chk("s_dcnt_clr", 32'(dut.dcnt_q), 32'h0);
        chk("s_f_oe", 32'(sram_oe_n), 32'h0);
        chk("s_f_addr", 32'(sram_addr), 32'h180);
      end
      if (c == 19) begin
        d_req = 1'b0;
        if_req = 1'b0;
      end
    end
    chk("s_dacks", 32'(dacks), 32'd4);
    chk("s_if_cycle", 32'(ifc), 32'd19);
    chk("s_drd_hold", d_rdata, 32'hA5A0_0080);
    tick();

    // byte store to lane 2
    d_req = 1'b1;
    d_we = 1'b1;
    d_sel = 2'b01;
    d_addr = 32'h302;
    d_wdata = 32'h0000_00AB;
    tick();
    chk("b_be", 32'(sram_be_n), 32'hB);
    chk("b_wd", sram_wdata, 32'hABAB_ABAB);
    chk("b_addr", 32'(sram_addr), 32'hC0);
    tick();
    chk("b_c2_ack", 32'(d_ack), 32'h0);
    tick();
    chk("b_wrec_ack", 32'(d_ack), 32'h1);
    chk("b_wrec_wd", sram_wdata, 32'hABAB_ABAB);
    chk("b_wrec_wdoe", 32'(sram_wdata_oe), 32'h1);
    d_req = 1'b0;
    tick();
    chk("b_c4_ack", 32'(d_ack), 32'h0);
    chk("b_c4_wdoe", 32'(sram_wdata_oe), 32'h0);
    chk("b_drd_hold", d_rdata, 32'hA5A0_0080);

    // halfword store to upper half, odd address
    d_req = 1'b1;
    d_sel = 2'b10;
    d_addr = 32'h403;
    d_wdata = 32'h1234_CDEF;
    tick();
    chk("h_be", 32'(sram_be_n), 32'h3);
    chk("h_wd", sram_wdata, 32'hCDEF_CDEF);
    chk("h_addr", 32'(sram_addr), 32'h100);
    tick();
    tick();
    chk("h_ack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    tick();

    // reset during the first read access cycle
    if_req = 1'b1;
    if_addr = 32'h500;
    tick();
    chk("r_c1_oe", 32'(sram_oe_n), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("r_async_ce", {30'b0, sram_ce_n, sram_oe_n}, 32'h3);
    chk("r_async_ack", 32'(if_ack), 32'h0);
    tick();
    chk("r_hold_ce", 32'(sram_ce_n), 32'h1);
    chk("r_hold_ack", 32'(if_ack), 32'h0);
    chk("r_hold_rd", if_rdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("r_n1_ce", {30'b0, sram_ce_n, sram_oe_n}, 32'h0);
    chk("r_n1_addr", 32'(sram_addr), 32'h140);
    tick();
    chk("r_n2_ack", 32'(if_ack), 32'h0);
    tick();
    chk("r_n3_ack", 32'(if_ack), 32'h1);
    chk("r_n3_rd", if_rdata, 32'hA5A0_0140);
    if_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter WAIT, default 2, number of SRAM access cycles per transfer (legal 1..7).
REQ-003 SHALL have parameter MAX_D, default 4, maximum consecutive data grants while a fetch is pending.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  32  fetch byte address
if_rdata  out  32  fetch read data
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_sel  in  2  00 word, 01 byte, 10 halfword, 11 word
d_addr  in  32  data byte address
d_wdata  in  32  store data, right-aligned
d_rdata  out  32  load data (full word)
d_ack  out  1  one-cycle data completion pulse
stall_req  out  1  pipeline stall request
sram_addr  out  ADDR_W  word address
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  4  byte enables, active-low
sram_wdata  out  32  write data
sram_wdata_oe  out  1  write-data tristate enable
sram_rdata  in  32  read data from SRAM

Function
REQ-006 SHALL implement FSM states IDLE, RD, WR, WREC; all SRAM outputs SHALL be registered.
REQ-007 In IDLE, a requester SHALL be eligible only if its req is high and its ack is low in that cycle.
REQ-008 Grant priority SHALL be data over fetch, except fetch wins when it is eligible and dcnt == MAX_D.
REQ-009 dcnt SHALL increment on each data grant (saturating at MAX_D) and clear to 0 on each fetch grant.
REQ-010 On grant at edge ending cycle T, the FSM SHALL latch owner, addr[ADDR_W+1:2], write data and byte enables; enter RD or WR; load cnt = WAIT-1; drive ce_n=0 with oe_n=0 (read) or we_n=0 and wdata_oe=1 (write) during cycles T+1..T+WAIT.
REQ-011 Fetches SHALL always be reads, with be_n=0000.
REQ-012 Data reads SHALL use be_n=0000 regardless of d_sel.
REQ-013 Write be_n SHALL be: word 0000; byte with only lane d_addr[1:0] low (lane 0 = bits 7:0); halfword 1100 if d_addr[1]=0 else 0011; d_addr[0] ignored for halfword.
REQ-014 Write data SHALL be: byte -> d_wdata[7:0] replicated to all 4 lanes; halfword -> d_wdata[15:0] replicated to both halves; word -> unchanged.
REQ-015 In RD/WR, cnt SHALL decrement each cycle; the cycle with cnt == 0 is the final access cycle.
REQ-016 Read completion: on the final access edge, sram_rdata SHALL be captured into the owner's rdata register, the owner's ack asserted for cycle T+WAIT+1, ce_n/oe_n driven 1, state set to IDLE; a new grant MAY occur in cycle T+WAIT+1.
REQ-017 Write completion: on the final access edge, we_n SHALL go 1 and the owner's ack assert for cycle T+WAIT+1 while the FSM sits in WREC with ce_n=1, addr and wdata held, wdata_oe=1; WREC SHALL last exactly one cycle, then IDLE with wdata_oe=0.
REQ-018 if_rdata/d_rdata SHALL hold their value until that port's next read completion; writes SHALL NOT modify d_rdata.
REQ-019 stall_req SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-020 Request changes during RD/WR/WREC SHALL NOT affect the transfer in progress.
REQ-021 Read latency SHALL be WAIT+1 cycles; back-to-back reads occupy WAIT+1 cycles each; writes occupy WAIT+2 cycles.

Reset
REQ-022 While rst=0, outputs SHALL asynchronously go to: ce_n=oe_n=we_n=1, be_n=1111, wdata_oe=0, sram_addr=0, sram_wdata=0, acks 0, rdata 0; state IDLE, dcnt=0, cnt=0.
REQ-023 Reset mid-transfer SHALL abort it with no ack; after release, the first grant SHALL occur no earlier than the first IDLE edge.

Verification
REQ-024 WAIT=2; if_req, if_addr=0x80000010 in cycle 0 -> sram_addr=0x4 with ce_n/oe_n low in cycles 1-2; if_ack=1 in cycle 3; if_rdata=SRAM word.
REQ-025 if_req and d_req (load) both in cycle 0 -> data granted first, d_ack cycle 3; fetch granted cycle 3, if_ack cycle 6.
REQ-026 d_req held continuously (MAX_D=4) with if_req pending -> exactly 4 data grants, then a fetch grant, then dcnt=0.
REQ-027 Byte store d_addr=0x...2, d_wdata=0x000000AB -> be_n=1011, sram_wdata=0xABABABAB, WREC one cycle, d_ack once.
REQ-028 rst driven low during RD cycle 1 -> ce_n/oe_n=1 immediately, no ack; after release with req held, a fresh full-length transfer completes.
